// File: rtl/fifo1_rr_enq_arbiter.sv
// -----------------------------------------------------------------------------
// fifo1_rr_enq_arbiter
//
// Purpose:
//   Shares the enq method of a single-element FIFO among NREQ requesters.
//   Requesters are served in round-robin order. One requester may keep the
//   grant for up to BURST consecutive grants while others are waiting. A
//   single registered output slot sits in front of the FIFO, so the enq data
//   and id come straight from flops. The enable is one AND gate with the
//   FIFO's ready signal.
//
// Parameters:
//   NREQ   number of requesters (2..8)
//   WIDTH  data width, matches the FIFO element
//   BURST  max consecutive grants to one requester while others wait (1..15)
//
// Ports:
//   CLK            clock
//   RST            asynchronous, active-high reset
//   req_valid      bit i: requester i has a word to enqueue
//   req_data       requester i data at [i*WIDTH +: WIDTH]
//   req_grant      one-hot or zero; requester i transfers this cycle when set
//   fifo_enq__RDY  FIFO can accept a word (independent of fifo_enq__ENA)
//   fifo_enq__ENA  enq call to the FIFO
//   fifo_enq_v     enq argument (slot data)
//   out_id         source index of the word held in the slot
//   grant_total    count of accepted requests, wraps at 2^16
// -----------------------------------------------------------------------------
module fifo1_rr_enq_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int BURST = 2,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_grant,
  input  logic                  fifo_enq__RDY,
  output logic                  fifo_enq__ENA,
  output logic [WIDTH-1:0]      fifo_enq_v,
  output logic [IDW-1:0]        out_id,
  output logic [15:0]           grant_total
);

  // One extra bit so last+k can be reduced modulo NREQ without overflow.
  localparam int SUMW = IDW + 1;

  localparam logic [3:0]     CNT_MAX  = 4'(BURST - 1);
  localparam logic [IDW-1:0] LAST_RST = IDW'(NREQ - 1);

  // Slot and arbitration state.
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [IDW-1:0]   out_id_q,    out_id_d;
  logic [IDW-1:0]   last_q,      last_d;
  logic [3:0]       cnt_q,       cnt_d;
  logic [15:0]      total_q,     total_d;

  // Combinational helpers.
  logic             can_accept_s;
  logic             grant_vld_s;
  logic [IDW-1:0]   winner_s;
  logic             found_s;
  logic [SUMW-1:0]  idx_sum_s;
  logic [IDW-1:0]   idx_s;
  logic [WIDTH-1:0] win_data_s;

  // The slot can take a new word if it is empty or draining this cycle.
  assign can_accept_s = !out_valid_q || fifo_enq__RDY;

  // Winner selection: stay on last while its burst allowance remains,
  // otherwise scan last+1 .. last (wrapping), so last is checked at the end.
  always_comb begin
    grant_vld_s = 1'b0;
    winner_s    = last_q;
    found_s     = 1'b0;
    idx_sum_s   = '0;
    idx_s       = '0;
    if (!can_accept_s || (req_valid == '0)) begin
      grant_vld_s = 1'b0;
    end else if ((cnt_q < CNT_MAX) && req_valid[last_q]) begin
      grant_vld_s = 1'b1;
      winner_s    = last_q;
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        idx_sum_s = {1'b0, last_q} + SUMW'(k);
        if (idx_sum_s >= SUMW'(NREQ)) begin
          idx_sum_s = idx_sum_s - SUMW'(NREQ);
        end else begin
          idx_sum_s = idx_sum_s;
        end
        idx_s = idx_sum_s[IDW-1:0];
        if (!found_s && req_valid[idx_s]) begin
          found_s  = 1'b1;
          winner_s = idx_s;
        end else begin
          found_s  = found_s;
        end
      end
      grant_vld_s = found_s;
    end
  end

  // One-hot grant toward the requesters.
  always_comb begin
    req_grant = '0;
    if (grant_vld_s) begin
      req_grant[winner_s] = 1'b1;
    end else begin
      req_grant = '0;
    end
  end

  // Select the winning requester's data word.
  always_comb begin
    win_data_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner_s == IDW'(i)) begin
        win_data_s = req_data[i*WIDTH +: WIDTH];
      end else begin
        win_data_s = win_data_s;
      end
    end
  end

  // Next-state for slot, round-robin pointer, burst counter and grant count.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    total_d     = total_q;
    if (grant_vld_s) begin
      out_valid_d = 1'b1;
      out_data_d  = win_data_s;
      out_id_d    = winner_s;
      last_d      = winner_s;
      total_d     = total_q + 16'd1;
      // Repeated wins by the same source saturate at CNT_MAX, which makes
      // the next search pass over it first; idle cycles leave cnt alone.
      if (winner_s == last_q) begin
        if (cnt_q < CNT_MAX) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          cnt_d = CNT_MAX;
        end
      end else begin
        cnt_d = 4'd0;
      end
    end else if (out_valid_q && fifo_enq__RDY) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers; reset discards any word held in the slot.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      last_q      <= LAST_RST;
      cnt_q       <= CNT_MAX;
      total_q     <= 16'd0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      total_q     <= total_d;
    end
  end

  assign fifo_enq__ENA = out_valid_q & fifo_enq__RDY;
  assign fifo_enq_v    = out_data_q;
  assign out_id        = out_id_q;
  assign grant_total   = total_q;

endmodule

// File: tb/tb_fifo1_rr_enq_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo1_rr_enq_arbiter
//
// Directed bench for fifo1_rr_enq_arbiter with NREQ=4, WIDTH=32, BURST=2.
// Inputs change 1 time unit after a rising edge; outputs are sampled
// between edges. Expected values are written out by hand per step.
// -----------------------------------------------------------------------------
module tb_fifo1_rr_enq_arbiter;

  logic         CLK = 1'b0;
  logic         RST;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_grant;
  logic         fifo_enq__RDY;
  logic         fifo_enq__ENA;
  logic [31:0]  fifo_enq_v;
  logic [1:0]   out_id;
  logic [15:0]  grant_total;

  int tests = 0;
  int fails = 0;

  fifo1_rr_enq_arbiter #(.NREQ(4), .WIDTH(32), .BURST(2)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_grant     (req_grant),
    .fifo_enq__RDY (fifo_enq__RDY),
    .fifo_enq__ENA (fifo_enq__ENA),
    .fifo_enq_v    (fifo_enq_v),
    .out_id        (out_id),
    .grant_total   (grant_total)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int exp_id;

    RST           = 1'b1;
    req_valid     = 4'b0000;
    req_data      = '0;
    fifo_enq__RDY = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;

    // Reset then idle
    chk("rst_vld_v", 32'(fifo_enq_v), 32'h0);
    chk("rst_id", 32'(out_id), 32'h0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_grant", 32'(req_grant), 32'h0);
      chk("idle_ena", 32'(fifo_enq__ENA), 32'h0);
      chk("idle_total", 32'(grant_total), 32'h0);
    end

    // Single requester 2 keeps winning
    req_valid          = 4'b0100;
    req_data[64 +: 32] = 32'h0000_00A5;
    #1;
    chk("single_grant0", 32'(req_grant), 32'h4);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("single_ena", 32'(fifo_enq__ENA), 32'h1);
      chk("single_v", fifo_enq_v, 32'hA5);
      chk("single_id", 32'(out_id), 32'h2);
      chk("single_total", 32'(grant_total), 32'(i + 1));
      chk("single_grant", 32'(req_grant), 32'h4);
    end
    req_valid = 4'b0000;
    #1;
    chk("drain_grant", 32'(req_grant), 32'h0);
    step();
    chk("drain_ena", 32'(fifo_enq__ENA), 32'h0);
    chk("drain_total", 32'(grant_total), 32'h4);

    // All requesting from reset: order 0,0,1,1,2,2,3,3,0,0
    RST = 1'b1;
    #1;
    RST = 1'b0;
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'h100 + 32'(i);
    #1;
    for (int k = 0; k < 10; k++) begin
      exp_id = (k / 2) % 4;
      chk("rr_grant", 32'(req_grant), 32'(1 << exp_id));
      step();
      chk("rr_id", 32'(out_id), 32'(exp_id));
      chk("rr_v", fifo_enq_v, 32'h100 + 32'(exp_id));
      chk("rr_ena", 32'(fifo_enq__ENA), 32'h1);
    end
    chk("rr_total", 32'(grant_total), 32'd10);

    // Back-pressure with id=1, v=0x11 in the slot
    req_valid          = 4'b0010;
    req_data[32 +: 32] = 32'h11;
    #1;
    chk("bp_grant_pre", 32'(req_grant), 32'h2);
    step();
    chk("bp_id_load", 32'(out_id), 32'h1);
    chk("bp_v_load", fifo_enq_v, 32'h11);
    chk("bp_total_load", 32'(grant_total), 32'd11);
    req_data[32 +: 32] = 32'h21;
    req_valid          = 4'b1111;
    fifo_enq__RDY      = 1'b0;
    #1;
    chk("bp_grant0", 32'(req_grant), 32'h0);
    chk("bp_ena0", 32'(fifo_enq__ENA), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_grant", 32'(req_grant), 32'h0);
      chk("bp_ena", 32'(fifo_enq__ENA), 32'h0);
      chk("bp_id", 32'(out_id), 32'h1);
      chk("bp_v", fifo_enq_v, 32'h11);
      chk("bp_total", 32'(grant_total), 32'd11);
    end
    fifo_enq__RDY = 1'b1;
    #1;
    chk("bp_rel_ena", 32'(fifo_enq__ENA), 32'h1);
    chk("bp_rel_v", fifo_enq_v, 32'h11);
    chk("bp_rel_grant", 32'(req_grant), 32'h2);
    step();
    chk("bp_refill_id", 32'(out_id), 32'h1);
    chk("bp_refill_v", fifo_enq_v, 32'h21);
    chk("bp_refill_ena", 32'(fifo_enq__ENA), 32'h1);
    chk("bp_refill_total", 32'(grant_total), 32'd12);

    // Async reset mid-burst
    #1;
    chk("mid_grant", 32'(req_grant), 32'h4);
    step();
    chk("mid_id", 32'(out_id), 32'h2);
    chk("mid_ena", 32'(fifo_enq__ENA), 32'h1);
    #2;
    RST = 1'b1;
    #1;
    chk("arst_ena", 32'(fifo_enq__ENA), 32'h0);
    chk("arst_total", 32'(grant_total), 32'h0);
    #1;
    RST = 1'b0;
    #1;
    chk("arst_first_grant", 32'(req_grant), 32'h1);
    step();
    chk("arst_first_id", 32'(out_id), 32'h0);
    chk("arst_first_v", fifo_enq_v, 32'h100);
    chk("arst_first_total", 32'(grant_total), 32'h1);

    // grant_total wrap after 65536 grants
    RST = 1'b1;
    #1;
    RST = 1'b0;
    for (int i = 0; i < 65536; i++) step();
    chk("wrap_total", 32'(grant_total), 32'h0);
    chk("wrap_id", 32'(out_id), 32'h3);
    chk("wrap_grant", 32'(req_grant), 32'h1);
    step();
    chk("wrap_next_id", 32'(out_id), 32'h0);
    chk("wrap_next_total", 32'(grant_total), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo1_rr_enq_arbiter.md
Name: fifo1_rr_enq_arbiter

Overview:
- Shares the enq method of one single-element FIFO (32-bit element, enq/deq/first with __ENA/__RDY handshakes) among NREQ requesters.
- Round-robin arbitration with a bounded burst allowance.
- One registered output slot, so fifo_enq__ENA and fifo_enq_v are timing-clean.
- Sits between producer methods and the FIFO's enq side; the deq/first side is untouched.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 32, data width; matches the FIFO element
- BURST, 2, max consecutive grants to one requester while others wait (1..15)

Ports:
- CLK  input  1  clock
- RST  input  1  asynchronous, active-high reset
- req_valid  input  NREQ  bit i: requester i has data to enqueue
- req_data  input  NREQ*WIDTH  slice i = [i*WIDTH +: WIDTH]
- req_grant  output  NREQ  one-hot or zero; the transfer from requester i occurs this cycle when bit i is 1
- fifo_enq__RDY  input  1  FIFO can accept (FIFO not full)
- fifo_enq__ENA  output  1  enq call to the FIFO
- fifo_enq_v  output  WIDTH  enq argument
- out_id  output  log2(NREQ)  source index of the word in the slot
- grant_total  output  16  count of accepted requests, wraps

Behaviour:
- Reset (async, RST=1):
  - out_valid=0, out_data=0, out_id=0, grant_total=0.
  - last=NREQ-1, cnt=BURST-1, so the first search starts at requester 0.
- Slot and output:
  - out_valid, out_data, out_id are registers.
  - fifo_enq_v = out_data.
  - fifo_enq__ENA = out_valid & fifo_enq__RDY (combinational).
  - fifo_enq__RDY never depends on fifo_enq__ENA.
- Acceptance:
  - can_accept = !out_valid | fifo_enq__RDY. This allows back-to-back: slot drain and refill in the same cycle.
- Grant, combinational from req_valid, last, cnt, can_accept:
  - If !can_accept or req_valid==0: req_grant=0.
  - Else if cnt<BURST-1 and req_valid[last]: winner=last.
  - Else: winner = first j with req_valid[j], searching last+1, last+2, ... mod NREQ, ending at last itself.
  - req_grant = onehot(winner). req_grant does not depend on req_data.
- On a clock with a grant:
  - out_data <= req_data[winner], out_id <= winner, out_valid <= 1.
  - cnt <= (winner==last) ? min(cnt+1, BURST-1) : 0.
  - last <= winner.
  - grant_total <= grant_total+1, mod 2^16.
- On a clock with no grant:
  - If fifo_enq__ENA: out_valid <= 0. Otherwise the slot holds.
  - last and cnt hold.
- Latency:
  - Request granted in cycle t appears on fifo_enq__ENA at t+1 at the earliest.
  - Sustained throughput is 1 word/cycle while fifo_enq__RDY=1.
- Back-pressure:
  - With out_valid=1 and fifo_enq__RDY=0, req_grant=0 and the slot is held unchanged.
  - Requesters keep req_valid and req_data stable until granted; the arbiter does not check this.
- Burst/fairness:
  - When cnt==BURST-1, the search passes over last first.
  - A lone requester continues to win; cnt saturates.
  - Worst-case wait for a continuously-requesting source is (NREQ-1)*BURST grants.
- Gaps: idle cycles do not reset cnt.
- Mid-operation reset: a word in the slot is discarded; no fifo_enq__ENA while RST=1.

Test Plan:
- Reset then idle: RST pulse, req_valid=0 -> req_grant=0, fifo_enq__ENA=0, grant_total=0 for 10 cycles.
- Single requester: req_valid=4'b0100, data=0x000000A5, fifo_enq__RDY=1 -> req_grant=4'b0100 each cycle; fifo_enq__ENA=1 from next cycle with v=0xA5 and out_id=2; grant_total increments by 1 per cycle.
- All requesting, BURST=2, RDY=1 -> grant order 0,0,1,1,2,2,3,3,0,0; grant_total=10 after 10 grants.
- Back-pressure: slot full with id=1 and v=0x11, fifo_enq__RDY=0 for 3 cycles -> req_grant=0 and outputs stable. RDY rises -> ENA=1 with v=0x11, and the next winner is loaded in the same cycle.
- Async reset mid-burst: assert RST between clock edges with out_valid=1 -> fifo_enq__ENA=0 immediately. After release, the first grant with all requesting goes to requester 0.
- grant_total wrap: 65536 grants -> counter returns to 0x0000 without disturbing arbitration.
